// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller.
// Turns per-stage stall requests into per-stage hold enables and bubble
// inserts, sequences redirect flushes (holding them pending while the
// issuing stage is stalled), and keeps stall statistics plus a watchdog.
module pipe_hazard_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int SW         = 3,
  parameter int CNT_W      = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rdy,
  input  logic [NUM_STAGES-1:0] stall_req,
  input  logic                  flush_req,
  input  logic [SW-1:0]         flush_stage,
  input  logic                  clr_stats,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] bubble,
  output logic [NUM_STAGES-1:0] flush,
  output logic                  flush_pending,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic                  stall_timeout
);

  // Watchdog counter only needs to reach TIMEOUT; keep at least one bit.
  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);
  localparam logic [NUM_STAGES-1:0] RST_STALL = NUM_STAGES'(1);

  logic [NUM_STAGES-1:0] enc_stall_s;
  logic [NUM_STAGES-1:0] enc_bubble_s;
  logic                  acc_s;
  logic                  new_valid_s;
  logic                  cand_valid_s;
  logic [SW-1:0]         cand_stage_s;
  logic                  blocked_s;
  logic                  fire_s;
  logic [NUM_STAGES-1:0] stall_s;
  logic [NUM_STAGES-1:0] bubble_s;
  logic [NUM_STAGES-1:0] flush_s;
  logic                  pend_valid_nxt_s;
  logic [SW-1:0]         pend_stage_nxt_s;
  logic [WD_W-1:0]       wd_nxt_s;

  logic                  pend_valid_r;
  logic [SW-1:0]         pend_stage_r;
  logic [CNT_W-1:0]      stall_cycles_r;
  logic [WD_W-1:0]       wd_r;
  logic                  stall_timeout_r;

  // Priority encode: every stage at or below the oldest stalling stage holds.
  always_comb begin
    acc_s        = 1'b0;
    enc_stall_s  = '0;
    enc_bubble_s = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      acc_s          = acc_s | stall_req[i];
      enc_stall_s[i] = acc_s;
    end
    for (int i = 1; i < NUM_STAGES; i++) begin
      enc_bubble_s[i] = enc_stall_s[i-1] & ~enc_stall_s[i];
    end
  end

  // Flush candidate selection and fire decision; the older stage always wins.
  always_comb begin
    new_valid_s = flush_req & (flush_stage >= SW'(1)) &
                  (flush_stage <= SW'(NUM_STAGES - 1));
    if (pend_valid_r && new_valid_s) begin
      cand_stage_s = (flush_stage > pend_stage_r) ? flush_stage : pend_stage_r;
    end else if (new_valid_s) begin
      cand_stage_s = flush_stage;
    end else begin
      cand_stage_s = pend_stage_r;
    end
    cand_valid_s = pend_valid_r | new_valid_s;
    blocked_s    = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      blocked_s = blocked_s | (stall_req[i] & (SW'(i) >= cand_stage_s));
    end
    fire_s = cand_valid_s & rdy & ~blocked_s;
  end

  // Per-stage outputs: rdy=0 freezes all, a firing flush releases all holds.
  always_comb begin
    stall_s  = '0;
    bubble_s = '0;
    flush_s  = '0;
    if (!rdy) begin
      stall_s = '1;
    end else if (fire_s) begin
      for (int i = 1; i < NUM_STAGES; i++) begin
        flush_s[i] = (SW'(i) <= cand_stage_s);
      end
    end else begin
      stall_s  = enc_stall_s;
      bubble_s = enc_bubble_s;
    end
  end

  // Pending flush next state: clear on fire, otherwise latch the candidate.
  always_comb begin
    pend_valid_nxt_s = pend_valid_r;
    pend_stage_nxt_s = pend_stage_r;
    if (fire_s) begin
      pend_valid_nxt_s = 1'b0;
      pend_stage_nxt_s = '0;
    end else if (cand_valid_s) begin
      pend_valid_nxt_s = 1'b1;
      pend_stage_nxt_s = cand_stage_s;
    end else begin
      pend_valid_nxt_s = pend_valid_r;
      pend_stage_nxt_s = pend_stage_r;
    end
  end

  // Watchdog next value: counts consecutive stalled ready cycles, rdy=0 holds.
  always_comb begin
    wd_nxt_s = wd_r;
    if (clr_stats) begin
      wd_nxt_s = '0;
    end else if (!rdy) begin
      wd_nxt_s = wd_r;
    end else if (|stall_req) begin
      wd_nxt_s = (wd_r >= WD_MAX) ? WD_MAX : wd_r + WD_W'(1);
    end else begin
      wd_nxt_s = '0;
    end
  end

  // Pending flush register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid_r <= 1'b0;
      pend_stage_r <= '0;
    end else begin
      pend_valid_r <= pend_valid_nxt_s;
      pend_stage_r <= pend_stage_nxt_s;
    end
  end

  // Saturating frontend-stall cycle counter; clear beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_r <= '0;
    end else if (clr_stats) begin
      stall_cycles_r <= '0;
    end else if (rdy && stall_s[1] && !fire_s && (stall_cycles_r != '1)) begin
      stall_cycles_r <= stall_cycles_r + CNT_W'(1);
    end else begin
      stall_cycles_r <= stall_cycles_r;
    end
  end

  // Watchdog counter and sticky timeout flag; TIMEOUT=0 never sets the flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_r            <= '0;
      stall_timeout_r <= 1'b0;
    end else begin
      wd_r <= wd_nxt_s;
      if (clr_stats) begin
        stall_timeout_r <= 1'b0;
      end else if ((TIMEOUT != 0) && (wd_nxt_s == WD_MAX)) begin
        stall_timeout_r <= 1'b1;
      end else begin
        stall_timeout_r <= stall_timeout_r;
      end
    end
  end

  // Combinational outputs snap to their reset values while rst_n is low.
  assign stall         = rst_n ? stall_s  : RST_STALL;
  assign bubble        = rst_n ? bubble_s : '0;
  assign flush         = rst_n ? flush_s  : '0;
  assign flush_pending = pend_valid_r;
  assign stall_cycles  = stall_cycles_r;
  assign stall_timeout = stall_timeout_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (5 stages, TIMEOUT=8, 8-bit counter).
// A behavioural model derives every expected output from the stall/flush rules
// with plain integer arithmetic; directed literal checks pin the model.
module tb_pipe_hazard_ctrl;

  localparam int NS = 5;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic [4:0]  stall_req;
  logic        flush_req;
  logic [2:0]  flush_stage;
  logic        clr_stats;
  logic [4:0]  stall;
  logic [4:0]  bubble;
  logic [4:0]  flush;
  logic        flush_pending;
  logic [7:0]  stall_cycles;
  logic        stall_timeout;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  // Model state
  int m_pend   = 0;  // 0 = nothing pending, else pending stage
  int m_cycles = 0;
  int m_wd     = 0;
  int m_to     = 0;

  pipe_hazard_ctrl #(.NUM_STAGES(5), .SW(3), .CNT_W(8), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .stall_req(stall_req),
    .flush_req(flush_req), .flush_stage(flush_stage), .clr_stats(clr_stats),
    .stall(stall), .bubble(bubble), .flush(flush), .flush_pending(flush_pending),
    .stall_cycles(stall_cycles), .stall_timeout(stall_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare process: checks the DUT against the model every cycle, then advances the model.
  always @(negedge clk) begin
    int h, f, es, eb, ef, wdn;
    bit nv, fire;
    if (chk_en) begin
      if (!rst_n) begin
        check("m_rst_stall", 32'(stall), 32'd1);
        check("m_rst_bubble", 32'(bubble), 32'd0);
        check("m_rst_flush", 32'(flush), 32'd0);
        check("m_rst_pend", 32'(flush_pending), 32'd0);
        check("m_rst_cycles", 32'(stall_cycles), 32'd0);
        check("m_rst_to", 32'(stall_timeout), 32'd0);
        m_pend = 0; m_cycles = 0; m_wd = 0; m_to = 0;
      end else begin
        h = -1;
        for (int i = 0; i < NS; i++) if (stall_req[i]) h = i;
        nv = flush_req && (flush_stage >= 1) && (flush_stage <= NS - 1);
        f = m_pend;
        if (nv && int'(flush_stage) > f) f = int'(flush_stage);
        fire = (f != 0) && rdy && ((stall_req >> f) == 5'd0);
        if (!rdy) es = 31;
        else if (fire || h < 0) es = 0;
        else es = (1 << (h + 1)) - 1;
        if (!rdy || fire || h < 0 || h == NS - 1) eb = 0;
        else eb = 1 << (h + 1);
        ef = fire ? ((1 << (f + 1)) - 2) : 0;
        check("m_stall", 32'(stall), 32'(es));
        check("m_bubble", 32'(bubble), 32'(eb));
        check("m_flush", 32'(flush), 32'(ef));
        check("m_pend", 32'(flush_pending), 32'(m_pend != 0));
        check("m_cycles", 32'(stall_cycles), 32'(m_cycles));
        check("m_to", 32'(stall_timeout), 32'(m_to));
        // advance model to the state after the coming edge
        m_pend = fire ? 0 : f;
        if (clr_stats) m_cycles = 0;
        else if (rdy && ((es >> 1) & 1) == 1 && !fire && m_cycles < 255) m_cycles = m_cycles + 1;
        if (clr_stats) wdn = 0;
        else if (!rdy) wdn = m_wd;
        else if (stall_req != 5'd0) wdn = (m_wd + 1 > 8) ? 8 : m_wd + 1;
        else wdn = 0;
        if (clr_stats) m_to = 0;
        else if (wdn == 8) m_to = 1;
        m_wd = wdn;
      end
    end
  end

  initial begin
    rst_n = 1'b0; rdy = 1'b1; stall_req = 5'd0; flush_req = 1'b0;
    flush_stage = 3'd0; clr_stats = 1'b0;
    chk_en = 1'b1;
    #2;
    check("rst_stall", 32'(stall), 32'h01);
    check("rst_bubble", 32'(bubble), 32'h00);
    check("rst_flush", 32'(flush), 32'h00);
    check("rst_pend", 32'(flush_pending), 32'h0);
    check("rst_cycles", 32'(stall_cycles), 32'h0);
    check("rst_to", 32'(stall_timeout), 32'h0);
    tick(); tick();
    rst_n = 1'b1;

    // Stall encode
    stall_req = 5'b01000; #1;
    check("enc3_stall", 32'(stall), 32'b01111);
    check("enc3_bubble", 32'(bubble), 32'b10000);
    tick();
    stall_req = 5'b10000; #1;
    check("enc4_stall", 32'(stall), 32'b11111);
    check("enc4_bubble", 32'(bubble), 32'b00000);
    tick();

    // Zero-latency flush
    stall_req = 5'd0; flush_req = 1'b1; flush_stage = 3'd2; #1;
    check("zl_flush", 32'(flush), 32'b00110);
    check("zl_stall", 32'(stall), 32'b00000);
    tick();
    flush_req = 1'b0; #1;
    check("zl_pend", 32'(flush_pending), 32'h0);
    tick();

    // Held flush, younger request ignored, fire on release
    stall_req = 5'b01000; flush_req = 1'b1; flush_stage = 3'd2; #1;
    check("hold_flush0", 32'(flush), 32'h0);
    tick();
    flush_stage = 3'd1; #1;
    check("hold_pend1", 32'(flush_pending), 32'h1);
    check("hold_flush1", 32'(flush), 32'h0);
    tick();
    flush_req = 1'b0; #1;
    check("hold_pend2", 32'(flush_pending), 32'h1);
    tick();
    stall_req = 5'd0; #1;
    check("rel_flush", 32'(flush), 32'b00110);
    check("rel_stall", 32'(stall), 32'b00000);
    tick(); #1;
    check("rel_pend", 32'(flush_pending), 32'h0);
    check("rel_flush_off", 32'(flush), 32'h0);

    // Older request replaces pending stage
    stall_req = 5'b01000; flush_req = 1'b1; flush_stage = 3'd2;
    tick();
    stall_req = 5'b10000; flush_stage = 3'd4; #1;
    check("repl_flush0", 32'(flush), 32'h0);
    check("repl_pend", 32'(flush_pending), 32'h1);
    tick();
    flush_req = 1'b0; stall_req = 5'd0; #1;
    check("repl_flush", 32'(flush), 32'b11110);
    tick();

    // rdy=0 freezes and latches, rdy=1 fires
    rdy = 1'b0; flush_req = 1'b1; flush_stage = 3'd3; #1;
    check("frz_stall", 32'(stall), 32'b11111);
    check("frz_flush", 32'(flush), 32'h0);
    check("frz_bubble", 32'(bubble), 32'h0);
    tick();
    rdy = 1'b1; flush_req = 1'b0; #1;
    check("frz_pend", 32'(flush_pending), 32'h1);
    check("frz_fire", 32'(flush), 32'b01110);
    tick();

    // Out-of-range flush stages are ignored
    flush_req = 1'b1; flush_stage = 3'd0; #1;
    check("inv0_flush", 32'(flush), 32'h0);
    tick();
    flush_stage = 3'd5; #1;
    check("inv5_flush", 32'(flush), 32'h0);
    tick();
    flush_req = 1'b0; #1;
    check("inv_pend", 32'(flush_pending), 32'h0);

    // Watchdog and stall counter
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0; #1;
    check("clr0_cycles", 32'(stall_cycles), 32'h0);
    check("clr0_to", 32'(stall_timeout), 32'h0);
    stall_req = 5'b00010;
    for (int k = 1; k <= 10; k++) begin
      tick(); #1;
      if (k == 7) check("wd_not_yet", 32'(stall_timeout), 32'h0);
      if (k == 8) check("wd_rise", 32'(stall_timeout), 32'h1);
    end
    stall_req = 5'd0;
    check("wd_cycles", 32'(stall_cycles), 32'd10);
    check("wd_sticky", 32'(stall_timeout), 32'h1);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0; #1;
    check("clr_cycles", 32'(stall_cycles), 32'h0);
    check("clr_to", 32'(stall_timeout), 32'h0);

    // Counter saturation
    stall_req = 5'b10000;
    repeat (300) tick();
    stall_req = 5'd0; #1;
    check("sat_cycles", 32'(stall_cycles), 32'd255);
    tick();

    // Asynchronous reset while a flush is pending
    stall_req = 5'b01000; flush_req = 1'b1; flush_stage = 3'd3;
    tick();
    flush_req = 1'b0; #1;
    check("mid_pend", 32'(flush_pending), 32'h1);
    #1 rst_n = 1'b0; #1;
    check("mid_stall", 32'(stall), 32'h01);
    check("mid_bubble", 32'(bubble), 32'h0);
    check("mid_flush", 32'(flush), 32'h0);
    check("mid_pend0", 32'(flush_pending), 32'h0);
    check("mid_cycles", 32'(stall_cycles), 32'h0);
    check("mid_to", 32'(stall_timeout), 32'h0);
    tick(); tick();
    rst_n = 1'b1; stall_req = 5'd0;
    tick();

    // Randomized phase against the model
    for (int n = 0; n < 3000; n++) begin
      rdy         = ($urandom % 5) != 0;
      stall_req   = (($urandom % 3) == 0) ? 5'd0 : 5'($urandom & $urandom);
      flush_req   = ($urandom % 3) == 0;
      flush_stage = 3'($urandom % 8);
      clr_stats   = ($urandom % 60) == 0;
      rst_n       = ($urandom % 500) != 0;
      tick();
    end
    rst_n = 1'b1; rdy = 1'b1; stall_req = 5'd0; flush_req = 1'b0; clr_stats = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
